// File: rtl/mux5_sel_if.sv
// Bus bundle for mux5_sel: the two address candidates, select, load enable
// and every result the block produces. The master side drives the candidates
// and controls; the slave side (the mux itself) drives the results.
interface mux5_sel_if #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] input1;    // candidate chosen when op=0 (rt field)
    logic [WIDTH-1:0] input2;    // candidate chosen when op=1 (rd field)
    logic             op;        // select
    logic             en;        // load enable for registered copy and counter
    logic [WIDTH-1:0] out;       // combinational mux result
    logic [WIDTH-1:0] out_q;     // registered mux result
    logic             op_q;      // registered select
    logic [CNT_W-1:0] sel2_cnt;  // saturating count of enabled op=1 cycles
    logic             out_zero;  // out==0 flag (tied low unless enabled)

    modport master (
        output input1, input2, op, en,
        input  out, out_q, op_q, sel2_cnt, out_zero
    );

    modport slave (
        input  input1, input2, op, en,
        output out, out_q, op_q, sel2_cnt, out_zero
    );
endinterface

// File: rtl/mux5_sel.sv
// mux5_sel: 2:1 select of a register-file write address (RegDst style).
// The combinational result feeds the single-cycle datapath directly; a
// registered copy, registered select and a saturating op=1 usage counter
// give a pipelined/debug view of the same decision.
// Optional feature macro: MUX5_ZERO_FLAG_EN -- when defined, out_zero flags a
// $zero destination (out==0); when undefined, out_zero is tied to 0.
module mux5_sel #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    mux5_sel_if.slave    bus
);

    logic [WIDTH-1:0] mux_out;

    logic [WIDTH-1:0] out_reg_q, out_reg_d;
    logic             op_reg_q,  op_reg_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    // Zero-latency select. The conditional operator is used rather than an
    // if/else so that an unknown op merges the two candidates bit by bit
    // (equal bits pass, differing bits go X) instead of silently picking input1.
    assign mux_out = bus.op ? bus.input2 : bus.input1;
    assign bus.out = mux_out;

    // Next-state for the registered copy and the saturating usage counter.
    always_comb begin
        // NOTE: every variable assigned here gets a default first (hold), so no
        // path leaves it unassigned and no latch is inferred.
        out_reg_d = out_reg_q;
        op_reg_d  = op_reg_q;
        cnt_d     = cnt_q;
        if (bus.en) begin
            out_reg_d = mux_out;
            op_reg_d  = bus.op;
            if (bus.op && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers; synchronous reset dominates the load enable.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update together from pre-edge values, independent of statement order.
        if (rst) begin
            out_reg_q <= '0;
            op_reg_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            out_reg_q <= out_reg_d;
            op_reg_q  <= op_reg_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.out_q    = out_reg_q;
    assign bus.op_q     = op_reg_q;
    assign bus.sel2_cnt = cnt_q;

`ifdef MUX5_ZERO_FLAG_EN
    // $zero-destination detect for downstream write suppression.
    assign bus.out_zero = (mux_out == '0);
`else
    assign bus.out_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mux5_sel.sv
// Directed, table-driven bench for mux5_sel. A 16-bit-counter instance runs
// the vector table; a 2-bit-counter instance exercises counter saturation.
module tb_mux5_sel;

`ifdef MUX5_ZERO_FLAG_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic rst_s;

    always #5 clk = ~clk;

    mux5_sel_if #(.WIDTH(5), .CNT_W(16)) bus_m ();
    mux5_sel_if #(.WIDTH(5), .CNT_W(2))  bus_s ();

    mux5_sel #(.WIDTH(5), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    mux5_sel #(.WIDTH(5), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst_s),
        .bus (bus_s)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        en;
        logic        op;
        logic [4:0]  in1;
        logic [4:0]  in2;
        logic [4:0]  exp_out;    // combinational, checked before the edge
        logic        exp_zero;   // out==0, only expected high when ZF
        logic [4:0]  exp_oq;     // registered values after the edge
        logic        exp_opq;
        logic [15:0] exp_cnt;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        //            rst   en    op    in1     in2     out     zero  out_q   op_q  cnt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'h01, 5'h02, 5'h01, 1'b0, 5'h00, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 5'h01, 5'h02, 5'h01, 1'b0, 5'h00, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 5'h01, 5'h02, 5'h02, 1'b0, 5'h02, 1'b1, 16'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 5'h1f, 5'h00, 5'h1f, 1'b0, 5'h02, 1'b1, 16'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 5'h1f, 5'h00, 5'h00, 1'b1, 5'h02, 1'b1, 16'd1};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 5'h1f, 5'h00, 5'h00, 1'b1, 5'h00, 1'b1, 16'd2};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 5'h1f, 5'h00, 5'h1f, 1'b0, 5'h1f, 1'b0, 16'd2};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 5'h03, 5'h0a, 5'h0a, 1'b0, 5'h00, 1'b0, 16'd0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 5'h03, 5'h0a, 5'h0a, 1'b0, 5'h0a, 1'b1, 16'd1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 5'h15, 5'h0a, 5'h15, 1'b0, 5'h15, 1'b0, 16'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 5'h00, 5'h1f, 5'h1f, 1'b0, 5'h15, 1'b0, 16'd1};

        rst = 1'b1;
        rst_s = 1'b1;
        bus_m.input1 = '0; bus_m.input2 = '0; bus_m.op = 1'b0; bus_m.en = 1'b0;
        bus_s.input1 = '0; bus_s.input2 = '0; bus_s.op = 1'b0; bus_s.en = 1'b0;

        // Main table: drive at negedge, check out just after, check registers after posedge.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            bus_m.en = vecs[i].en;
            bus_m.op = vecs[i].op;
            bus_m.input1 = vecs[i].in1;
            bus_m.input2 = vecs[i].in2;
            #1;
            check($sformatf("v%0d out", i), 32'(bus_m.out), 32'(vecs[i].exp_out));
            check($sformatf("v%0d out_zero", i), 32'(bus_m.out_zero), 32'(ZF & vecs[i].exp_zero));
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_q", i), 32'(bus_m.out_q), 32'(vecs[i].exp_oq));
            check($sformatf("v%0d op_q", i), 32'(bus_m.op_q), 32'(vecs[i].exp_opq));
            check($sformatf("v%0d sel2_cnt", i), 32'(bus_m.sel2_cnt), 32'(vecs[i].exp_cnt));
        end

        // Combinational response without any clock edge: flip op mid-cycle.
        @(negedge clk);
        bus_m.en = 1'b0;
        bus_m.input1 = 5'h0c;
        bus_m.input2 = 5'h13;
        bus_m.op = 1'b0;
        #1 check("comb op0", 32'(bus_m.out), 32'h0c);
        bus_m.op = 1'b1;
        #1 check("comb op1", 32'(bus_m.out), 32'h13);

        // Saturation on the 2-bit counter instance: reset, then 5 enabled op=1 edges.
        @(negedge clk);
        rst_s = 1'b1;
        @(posedge clk);
        #1 check("sat reset cnt", 32'(bus_s.sel2_cnt), 32'd0);
        @(negedge clk);
        rst_s = 1'b0;
        bus_s.en = 1'b1;
        bus_s.op = 1'b1;
        bus_s.input1 = 5'h04;
        bus_s.input2 = 5'h1b;
        for (int k = 0; k < 5; k++) begin
            logic [1:0] exp_c;
            exp_c = (k < 3) ? 2'(k + 1) : 2'd3;
            @(posedge clk);
            #1 check($sformatf("sat edge%0d cnt", k + 1), 32'(bus_s.sel2_cnt), 32'(exp_c));
        end
        check("sat out_q", 32'(bus_s.out_q), 32'h1b);

        // Hold with en=0 at saturation, then mid-run reset clears all registers.
        @(negedge clk);
        bus_s.en = 1'b0;
        bus_s.op = 1'b0;
        @(posedge clk);
        #1;
        check("sat hold cnt", 32'(bus_s.sel2_cnt), 32'd3);
        check("sat hold op_q", 32'(bus_s.op_q), 32'd1);
        @(negedge clk);
        rst_s = 1'b1;
        bus_s.en = 1'b1;
        bus_s.op = 1'b1;
        #1 check("sat rst out tracks", 32'(bus_s.out), 32'h1b);
        @(posedge clk);
        #1;
        check("sat rst cnt", 32'(bus_s.sel2_cnt), 32'd0);
        check("sat rst out_q", 32'(bus_s.out_q), 32'd0);
        check("sat rst op_q", 32'(bus_s.op_q), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
